serial_negate_16bit: RTL

- Multi-cycle, bit-serial conditional negator.
- The combinational datapath inverts operands for subtraction. This block performs the complementary step serially: it applies invert plus carry-in, producing Out = inv ? (~In + 1) : In, one bit per clock, LSB first.
- Used by the multicycle multiply/divide sequencer to take magnitudes and restore signs without a second 16-bit adder.

---
 rtl/serial_negate_16bit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_negate_16bit.sv
// Bit-serial conditional negator: Out = inv ? (~In + 1) : In, one bit per clock, LSB first.
// Uniform 16-cycle latency regardless of data or inv.
module serial_negate_16bit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             ovf
);

  if (WIDTH != (32'd1 << CNT_W)) begin : g_bad_param
    $error("serial_negate_16bit: WIDTH must equal 2**CNT_W");
  end

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             last_bit;
  logic             bit_x;
  logic             res_bit;
  logic [WIDTH-1:0] res_shifted;

  assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
  assign bit_x       = opd_q[0] ^ neg_q;
  assign res_bit     = bit_x ^ carry_q;
  assign res_shifted = {res_bit, res_q[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StShift: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    opd_d   = opd_q;
    res_d   = res_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opd_d   = In;
          neg_d   = inv;
          carry_d = inv;
          cnt_d   = '0;
        end
      end
      StShift: begin
        res_d   = res_shifted;
        carry_d = bit_x & carry_q;
        opd_d   = opd_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          out_d = res_shifted;
          // opd_q[0] now holds the original input MSB
          ovf_d = neg_q & opd_q[0] & res_bit;
        end
      end
      StDone:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opd_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opd_q   <= opd_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Out = out_q;
  assign ovf = ovf_q;

endmodule
